// File: rtl/serial_pkg.sv
// Shared definitions for the serial byte link: line levels, receiver FSM encodings
// and the default word size used by both ends of the link.
package serial_pkg;

    localparam int DEFAULT_WORD_SIZE    = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 8;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    localparam logic [2:0] ST_WAIT_IDLE = 3'd0;
    localparam logic [2:0] ST_IDLE      = 3'd1;
    localparam logic [2:0] ST_START     = 3'd2;
    localparam logic [2:0] ST_DATA      = 3'd3;
    localparam logic [2:0] ST_STOP      = 3'd4;

    // Outcome of the stop-bit sample on the current clock.
    typedef enum logic [1:0] {
        FRAME_NONE = 2'd0,
        FRAME_OK   = 2'd1,
        FRAME_BAD  = 2'd2
    } frame_event_t;

    function automatic logic stop_ok(input logic sample);
        return sample == STOP_BIT;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level; both flops reset to RESET_VALUE.
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic meta;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            meta <= RESET_VALUE;
            o_q  <= RESET_VALUE;
        end else begin
            meta <= i_d;
            o_q  <= meta;
        end
    end

endmodule

// File: rtl/serial_receiver.sv
// Serial byte-link receiver: start / WORD_SIZE data bits LSB-first / stop frames,
// oversampled CLKS_PER_BIT times and sampled mid-bit, with framing and overrun flags.
module serial_receiver
    import serial_pkg::*;
#(
    parameter int WORD_SIZE    = DEFAULT_WORD_SIZE,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_serial_in,
    input  logic                 i_byte_ack,
    output logic [WORD_SIZE-1:0] o_data_bus,
    output logic                 o_byte_ready,
    output logic                 o_framing_err,
    output logic                 o_overrun_err
);

    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(WORD_SIZE + 1);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(WORD_SIZE - 1);

    logic                 rx;
    logic [2:0]           state;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [WORD_SIZE-1:0] shift_reg;
    logic [WORD_SIZE-1:0] shift_next;
    logic                 bit_end;
    logic                 half_end;
    frame_event_t         frame_ev;

    sync_2ff #(
        .RESET_VALUE(IDLE_LEVEL)
    ) u_sync (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .i_d    (i_serial_in),
        .o_q    (rx)
    );

    always_comb begin
        bit_end    = (cnt == BIT_LAST);
        half_end   = (cnt == HALF_LAST);
        // LSB arrives first, so each new bit enters at the top and drifts down.
        shift_next = shift_reg >> 1;
        shift_next[WORD_SIZE-1] = rx;
        frame_ev   = FRAME_NONE;
        if (state == ST_STOP && bit_end) begin
            frame_ev = stop_ok(rx) ? FRAME_OK : FRAME_BAD;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state     <= ST_WAIT_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            case (state)
                ST_WAIT_IDLE: begin
                    if (rx == IDLE_LEVEL) state <= ST_IDLE;
                end
                ST_IDLE: begin
                    cnt <= '0;
                    if (rx == START_BIT) state <= ST_START;
                end
                ST_START: begin
                    // A start bit that is gone by mid-bit was a glitch; drop it silently.
                    if (half_end) begin
                        cnt <= '0;
                        if (rx == START_BIT) begin
                            state   <= ST_DATA;
                            bit_idx <= '0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        cnt       <= '0;
                        shift_reg <= shift_next;
                        bit_idx   <= bit_idx + 1'b1;
                        if (bit_idx == IDX_LAST) state <= ST_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        state <= (frame_ev == FRAME_OK) ? ST_IDLE : ST_WAIT_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_WAIT_IDLE;
            endcase
        end
    end

    // Host handshake: o_byte_ready is the valid flag for o_data_bus; a one-cycle i_byte_ack
    // consumes it and clears both error flags. A completing word or a new error on the same
    // edge as the ack takes priority over the clear.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_data_bus    <= '0;
            o_byte_ready  <= 1'b0;
            o_framing_err <= 1'b0;
            o_overrun_err <= 1'b0;
        end else begin
            if (frame_ev == FRAME_OK) begin
                o_data_bus   <= shift_reg;
                o_byte_ready <= 1'b1;
            end else if (i_byte_ack) begin
                o_byte_ready <= 1'b0;
            end

            if (frame_ev == FRAME_OK && o_byte_ready && !i_byte_ack) begin
                o_overrun_err <= 1'b1;
            end else if (i_byte_ack) begin
                o_overrun_err <= 1'b0;
            end

            if (frame_ev == FRAME_BAD) begin
                o_framing_err <= 1'b1;
            end else if (i_byte_ack) begin
                o_framing_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_receiver.sv
// Directed and randomized frames against a flag-level model of the serial receiver.
module tb_serial_receiver;
    import serial_pkg::*;

    localparam int W          = 8;
    localparam int CPB        = 8;
    localparam int HALF       = CPB / 2;
    localparam int FRAME_CLKS = (W + 2) * CPB;
    localparam int READY_LAT  = 2 + HALF + (W + 1) * CPB;

    logic         i_clk       = 1'b0;
    logic         i_reset     = 1'b0;
    logic         i_serial_in = 1'b1;
    logic         i_byte_ack  = 1'b0;
    logic [W-1:0] o_data_bus;
    logic         o_byte_ready;
    logic         o_framing_err;
    logic         o_overrun_err;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   rise_cyc = -1;
    logic prev_ready = 1'b0;

    // Reference model: what the host should see after each frame / ack.
    logic [W-1:0] exp_q[$];
    logic [W-1:0] m_data;
    logic         m_ready, m_ferr, m_oerr;

    serial_receiver #(
        .WORD_SIZE   (W),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_serial_in  (i_serial_in),
        .i_byte_ack   (i_byte_ack),
        .o_data_bus   (o_data_bus),
        .o_byte_ready (o_byte_ready),
        .o_framing_err(o_framing_err),
        .o_overrun_err(o_overrun_err)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) begin
        cyc++;
        #1;
        if (o_byte_ready && !prev_ready) rise_cyc = cyc;
        prev_ready = o_byte_ready;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_data"},  32'(o_data_bus),    32'(m_data));
        check({tag, "_ready"}, 32'(o_byte_ready),  32'(m_ready));
        check({tag, "_ferr"},  32'(o_framing_err), 32'(m_ferr));
        check({tag, "_oerr"},  32'(o_overrun_err), 32'(m_oerr));
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_data  = '0;
        m_ready = 1'b0;
        m_ferr  = 1'b0;
        m_oerr  = 1'b0;
    endtask

    task automatic model_ack();
        m_ready = 1'b0;
        m_ferr  = 1'b0;
        m_oerr  = 1'b0;
    endtask

    task automatic model_frame(input logic [W-1:0] d, input logic stop, input bit ack);
        if (stop) begin
            if (m_ready && !ack) m_oerr = 1'b1;
            else if (ack)        m_oerr = 1'b0;
            if (ack) m_ferr = 1'b0;
            exp_q.push_back(d);
            m_data  = exp_q[$];
            m_ready = 1'b1;
        end else begin
            m_ferr = 1'b1;
            if (ack) begin
                m_ready = 1'b0;
                m_oerr  = 1'b0;
            end
        end
    endtask

    task automatic idle(input int n, input logic level);
        repeat (n) begin
            @(negedge i_clk);
            i_serial_in = level;
            i_byte_ack  = 1'b0;
        end
    endtask

    task automatic pulse_ack();
        @(negedge i_clk);
        i_byte_ack = 1'b1;
        @(negedge i_clk);
        i_byte_ack = 1'b0;
        model_ack();
    endtask

    // Drives one whole frame; k is the first edge that sees the start bit.
    // With ack_done set, the ack is high on the edge where the stop bit is judged.
    task automatic send_frame(input logic [W-1:0] d, input logic stop, input bit ack_done,
                              output int k);
        logic [W+1:0] bits;
        bits = {stop, d, START_BIT};
        k = 0;
        for (int j = 0; j < FRAME_CLKS; j++) begin
            @(negedge i_clk);
            if (j == 0) k = cyc + 1;
            i_serial_in = bits[j / CPB];
            i_byte_ack  = ack_done && (j == READY_LAT);
        end
    endtask

    initial begin
        int           k;
        logic [W-1:0] d;
        logic         stop;
        bit           ackd;
        logic [W+1:0] fbits;

        #1 i_reset = 1'b1;
        #1;
        model_reset();
        check_outputs("reset");
        repeat (3) @(negedge i_clk);
        i_reset = 1'b0;
        idle(5, 1'b1);

        // 1: single frame, latency, ack
        rise_cyc = -1;
        send_frame(8'hA5, 1'b1, 1'b0, k);
        model_frame(8'hA5, 1'b1, 1'b0);
        check_outputs("t1");
        check("t1_latency", 32'(rise_cyc), 32'(k + READY_LAT));
        idle(2, 1'b1);
        pulse_ack();
        check_outputs("t1_ack");

        // 2: back-to-back frames without ack -> overrun
        send_frame(8'h00, 1'b1, 1'b0, k);
        model_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0, k);
        model_frame(8'hFF, 1'b1, 1'b0);
        idle(2, 1'b1);
        check_outputs("t2");
        pulse_ack();
        check_outputs("t2_ack");

        // 3: bad stop bit, line low, then a good frame
        send_frame(8'h3C, 1'b0, 1'b0, k);
        model_frame(8'h3C, 1'b0, 1'b0);
        idle(20, 1'b0);
        idle(10, 1'b1);
        check_outputs("t3_ferr");
        send_frame(8'h81, 1'b1, 1'b0, k);
        model_frame(8'h81, 1'b1, 1'b0);
        idle(2, 1'b1);
        check_outputs("t3_next");
        pulse_ack();
        check_outputs("t3_ack");

        // 4: short start glitch is ignored
        idle(3, 1'b0);
        idle(20, 1'b1);
        check_outputs("t4_glitch");
        check("t4_state", 32'(dut.state), 32'(ST_IDLE));
        send_frame(8'h5A, 1'b1, 1'b0, k);
        model_frame(8'h5A, 1'b1, 1'b0);
        idle(2, 1'b1);
        check_outputs("t4_next");

        // 5: reset during data bit 4, line low at release
        fbits = {1'b1, 8'hF0, START_BIT};
        for (int j = 0; j < 4 * CPB + CPB + HALF; j++) begin
            @(negedge i_clk);
            i_serial_in = fbits[j / CPB];
        end
        @(negedge i_clk);
        i_serial_in = 1'b0;
        i_reset     = 1'b1;
        #1;
        model_reset();
        check_outputs("t5_reset");
        @(negedge i_clk);
        i_reset = 1'b0;
        @(negedge i_clk);
        idle(40, 1'b1);
        check_outputs("t5_quiet");
        send_frame(8'h0F, 1'b1, 1'b0, k);
        model_frame(8'h0F, 1'b1, 1'b0);
        idle(2, 1'b1);
        check_outputs("t5_next");

        // 6: ack on the completion edge with previous word unread
        pulse_ack();
        send_frame(8'h11, 1'b1, 1'b0, k);
        model_frame(8'h11, 1'b1, 1'b0);
        check_outputs("t6_first");
        send_frame(8'h42, 1'b1, 1'b1, k);
        model_frame(8'h42, 1'b1, 1'b1);
        idle(2, 1'b1);
        check_outputs("t6_ack_done");
        pulse_ack();

        // Break: line held low gives one framing error and no words
        send_frame(8'h00, 1'b0, 1'b0, k);
        model_frame(8'h00, 1'b0, 1'b0);
        idle(300, 1'b0);
        check_outputs("break");
        pulse_ack();
        idle(100, 1'b0);
        check_outputs("break_ack");
        idle(10, 1'b1);

        // Randomized frames, stop bits, acks and gaps
        for (int n = 0; n < 20; n++) begin
            d    = W'($urandom_range(0, 255));
            stop = ($urandom_range(0, 4) != 0);
            ackd = stop && ($urandom_range(0, 3) == 0);
            send_frame(d, stop, ackd, k);
            model_frame(d, stop, ackd);
            if (!stop) begin
                idle(int'($urandom_range(0, 12)), 1'b0);
                idle(int'($urandom_range(4, 12)), 1'b1);
            end else begin
                idle(int'($urandom_range(0, 6)), 1'b1);
            end
            check_outputs("rand");
            if ($urandom_range(0, 1) == 1) begin
                pulse_ack();
                check_outputs("rand_ack");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
